// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, flag layout and
// the pending-counter occupancy encoding.
package cpu_pkg;

   localparam logic [4:0] OP_BEQ = 5'b10011;
   localparam logic [4:0] OP_BLT = 5'b10100;
   localparam logic [4:0] OP_BGT = 5'b10101;
   localparam logic [4:0] OP_BNE = 5'b10110;

   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   typedef logic [1:0] flags_t;

   typedef enum logic [1:0] {
      PEND_EMPTY,
      PEND_BUSY,
      PEND_FULL
   } pend_state_t;

   function automatic logic is_branch(input logic [4:0] opcode);
      logic hit;
      hit = 1'b0;
      unique case (opcode)
         OP_BEQ, OP_BLT, OP_BGT, OP_BNE: hit = 1'b1;
         default:                        hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/flag_pend_counter.sv
// Saturating count of flag-setters between ID issue and EX
// writeback, with flush, occupancy state and sticky error.
module flag_pend_counter
   import cpu_pkg::*;
#(
   parameter int MAX_PEND = 3,
   parameter int PW       = $clog2(MAX_PEND + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          flush,
   input  logic          inc,
   input  logic          dec,
   output logic [PW-1:0] pend,
   output pend_state_t   state,
   output logic          err
);

   localparam logic [PW-1:0] MAX_V = PW'(MAX_PEND);
   localparam logic [PW-1:0] ONE_V = PW'(1);

   logic [PW-1:0] cnt_d, cnt_q;
   logic          err_d, err_q;
   pend_state_t   state_d, state_q;

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (en) begin
         if (flush) begin
            cnt_d = '0;
         end else if (inc && !dec) begin
            if (cnt_q == MAX_V) err_d = 1'b1;
            else                cnt_d = cnt_q + ONE_V;
         end else if (dec && !inc) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - ONE_V;
         end
      end
   end

   always_comb begin
      state_d = PEND_BUSY;
      if (cnt_d == '0)         state_d = PEND_EMPTY;
      else if (cnt_d == MAX_V) state_d = PEND_FULL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         err_q   <= 1'b0;
         state_q <= PEND_EMPTY;
      end else begin
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         state_q <= state_d;
      end
   end

   assign pend  = cnt_q;
   assign state = state_q;
   assign err   = err_q;

endmodule

// File: rtl/branch_flag_unit.sv
// Zero/negative flag producer for the branch resolver, with
// in-flight tracking, branch stall and optional EX bypass.
module branch_flag_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MAX_PEND = 3,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [4:0]        id_opcode,
   input  logic              id_sets_flags,
   input  logic              ex_valid,
   input  logic              ex_flag_we,
   input  logic [DATA_W-1:0] ex_result,
   output logic [1:0]        flags,
   output logic              flags_stall,
   output logic              pend_err
);

   localparam int PW = $clog2(MAX_PEND + 1);

   flags_t        live_flags;
   flags_t        flag_d, flag_q;
   logic          id_branch;
   logic          issue, retire;
   logic          fwd;
   logic [PW-1:0] pend;
   pend_state_t   pend_state;

   always_comb begin
      live_flags         = '0;
      live_flags[FLAG_Z] = (ex_result == '0);
      live_flags[FLAG_N] = ex_result[DATA_W-1];
   end

   assign id_branch = id_valid && is_branch(id_opcode);
   assign retire    = ex_valid && ex_flag_we && !pipe_stall;

   // Last in-flight setter retiring now: its flags are already live.
   assign fwd = BYPASS && (pend == PW'(1)) && retire;

   assign flags_stall = id_branch
                     && (pend_state != PEND_EMPTY)
                     && !fwd;

   assign issue = id_valid && id_sets_flags
               && !flags_stall && !pipe_stall;

   always_comb begin
      flag_d = flag_q;
      if (retire) flag_d = live_flags;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) flag_q <= '0;
      else     flag_q <= flag_d;
   end

   assign flags = fwd ? live_flags : flag_q;

   flag_pend_counter #(
      .MAX_PEND (MAX_PEND),
      .PW       (PW)
   ) u_pend (
      .clk   (clk),
      .rst   (rst),
      .en    (!pipe_stall),
      .flush (flush),
      .inc   (issue),
      .dec   (retire),
      .pend  (pend),
      .state (pend_state),
      .err   (pend_err)
   );

endmodule

// File: doc/branch_flag_unit.md
# branch_flag_unit

Producer side of the branch-flag interface. Derives the zero/negative flags from each flag-setting ALU result in EX, holds them in an architectural flag register, and drives the 2-bit `flags` bus consumed by the branch resolver (BEQ/BLT/BGT/BNE). It also tracks flag-setting instructions still in flight between ID and EX. It raises a stall when a conditional branch in ID would otherwise read stale flags.

## Interface
Parameters:
- DATA_W, 32, ALU result width.
- MAX_PEND, 3, maximum flag-setting instructions in flight between ID issue and EX writeback.
- BYPASS, 1, when 1 forward same-cycle EX flags to the `flags` bus; when 0 always stall until registered.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- pipe_stall  in  1  global pipeline freeze; no issue, retire or flag update while high.
- flush  in  1  squash all issued-but-unretired instructions.
- id_valid  in  1  instruction present in ID.
- id_opcode  in  5  ID opcode.
- id_sets_flags  in  1  decoder: ID instruction writes flags.
- ex_valid  in  1  instruction present in EX.
- ex_flag_we  in  1  EX instruction writes flags.
- ex_result  in  DATA_W  ALU result.
- flags  out  2  {Z,N}: bit1 = zero, bit0 = negative.
- flags_stall  out  1  hold ID; branch must not resolve this cycle.
- pend_err  out  1  sticky: pending counter overflow or underflow attempted.

## Operation
- Flag derivation: Z = (ex_result == 0); N = ex_result[DATA_W-1].
- Flag register loads {Z,N} on the rising edge when ex_valid & ex_flag_we & !pipe_stall. Otherwise it holds.
- id_branch = id_valid & id_opcode in {BEQ 10011, BLT 10100, BGT 10101, BNE 10110}.
- issue = id_valid & id_sets_flags & !flags_stall & !pipe_stall; retire = ex_valid & ex_flag_we & !pipe_stall.
- Pending counter, range 0..MAX_PEND:
  - issue only: +1.
  - retire only: -1.
  - both or neither: unchanged.
  - flush: forced to 0, overriding issue/retire. The flag register still loads on a retire in the same cycle.
- Error handling:
  - Issue at MAX_PEND: counter saturates and pend_err sets.
  - Retire at 0: counter stays 0 and pend_err sets.
  - pend_err clears only on rst.
- Stall and forwarding:
  - flags_stall = id_branch & (pend != 0) & !(BYPASS & pend == 1 & retire).
  - BYPASS path: when pend == 1 & retire, `flags` combinationally carries the live {Z,N} from ex_result. In all other cases `flags` is the register output.
  - flags_stall has no effect when pend == 0.
- Counter states: EMPTY (0), PENDING (1..MAX_PEND-1), FULL (MAX_PEND).
- Transitions: EMPTY→PENDING on issue; PENDING→EMPTY on retire at 1; PENDING→FULL on issue at MAX_PEND-1; any state→EMPTY on flush.

## Timing
- Reset values: flags = 2'b00, pend = 0, pend_err = 0, flags_stall = 0.
- Asserting rst mid-operation clears all state immediately, asynchronously.
- Registered flag latency: a retire at edge N makes the flags visible from just after edge N; a branch in ID sees them in cycle N+1.
- Forwarded flag latency: 0 cycles, same cycle as EX.
- flags_stall is combinational from pend, id_*, and the retire path. It rises in the same cycle the branch enters ID.
- pipe_stall freezes every register except the asynchronous reset path.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants BEQ/BLT/BGT/BNE.
  - Flag bit indices FLAG_Z = 1, FLAG_N = 0.
  - `typedef logic [1:0] flags_t`.
  - `is_branch(opcode)` function.
- One sub-module, `flag_pend_counter`: saturating up/down counter with flush and sticky error. The top level holds flag derivation, the flag register and the bypass mux.

## Test plan
- Reset, then retire ex_result = 0 → flags = 2'b10. Then retire 32'h8000_0001 → flags = 2'b01. Then retire 32'h0000_0005 → flags = 2'b00.
- Issue ADD (id_sets_flags), then next cycle BEQ in ID with BYPASS = 0:
  - flags_stall = 1 until the ADD retires.
  - flags = 2'b10 the cycle after the retire of result 0.
  - Stall drops in that cycle.
- Same sequence with BYPASS = 1: BEQ in ID in the same cycle as retire at pend = 1 → flags_stall = 0 and flags = live 2'b10.
- Issue 3 flag-setters with MAX_PEND = 3 and no retire, then attempt a 4th → pend stays 3, pend_err = 1, and it stays set after later retires.
- Simultaneous issue and retire at pend = 2 → pend stays 2. Flush with pend = 2 → pend = 0 and a following BLT in ID has no stall.
- Assert rst mid-stall with pend = 2 and flags = 2'b01 → all outputs return to reset values before the next edge. pipe_stall held high for 3 cycles during a retire → flags unchanged.
